// File: rtl/tile_draw_scheduler.sv
// tile_draw_scheduler: walks the 4x4 board and time-shares one glyph drawer across all dirty, non-blank tiles
// Ports: clk/resetn clock and async active-low reset; start begins a pass (IDLE only);
// board/dirty_mask are latched at start; hold stalls drawing; busy/done report pass status;
// tile_index/tile_value/x_origin/y_origin describe the selected tile;
// glyph_resetn/glyph_enable drive the glyph drawer; plot is the VGA strobe.
module tile_draw_scheduler #(
  parameter int TILE_SIZE    = 30,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int GLYPH_CYCLES = 121
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [63:0] board,
  input  logic [15:0] dirty_mask,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic [3:0]  tile_index,
  output logic [3:0]  tile_value,
  output logic [7:0]  x_origin,
  output logic [6:0]  y_origin,
  output logic        glyph_resetn,
  output logic        glyph_enable,
  output logic        plot
);
  localparam int CW = $clog2(GLYPH_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(GLYPH_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SCAN, CLEAR, DRAW, FIN} state_t;
  state_t state;
  logic [63:0] board_q;
  logic [15:0] mask_q;
  logic [CW-1:0] cnt;
  logic sel;
  assign tile_value   = board_q[{tile_index, 2'b00} +: 4];
  assign sel          = mask_q[tile_index] && (tile_value != 4'd0);
  assign x_origin     = 8'(ORIGIN_X + 32'(tile_index[1:0]) * TILE_SIZE);
  assign y_origin     = 7'(ORIGIN_Y + 32'(tile_index[3:2]) * TILE_SIZE);
  assign busy         = state != IDLE;
  assign done         = state == FIN;
  assign glyph_resetn = state != CLEAR;
  // hold gates the drawer in the same cycle so no enabled cycle is lost
  assign glyph_enable = (state == DRAW) && !hold;
  assign plot         = glyph_enable;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      board_q    <= '0;
      mask_q     <= '0;
      tile_index <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          board_q    <= board;
          mask_q     <= dirty_mask;
          tile_index <= '0;
          state      <= SCAN;
        end
        SCAN: if (sel) state <= CLEAR;
          else if (tile_index == 4'd15) state <= FIN;
          else tile_index <= tile_index + 4'd1;
        CLEAR: begin
          cnt   <= '0;
          state <= DRAW;
        end
        DRAW: if (!hold) begin
          if (cnt == LAST) begin
            state <= (tile_index == 4'd15) ? FIN : SCAN;
            if (tile_index != 4'd15) tile_index <= tile_index + 4'd1;
          end else cnt <= cnt + CW'(1);
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_draw_scheduler.sv
// tb_tile_draw_scheduler: directed self-checking bench for tile_draw_scheduler
module tb_tile_draw_scheduler;
  logic clk = 0, resetn = 0, start = 0, hold = 0;
  logic [63:0] board = '0;
  logic [15:0] dirty_mask = '0;
  logic busy, done, glyph_resetn, glyph_enable, plot;
  logic [3:0] tile_index, tile_value;
  logic [7:0] x_origin;
  logic [6:0] y_origin;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  tile_draw_scheduler dut (
    .clk(clk), .resetn(resetn), .start(start), .board(board), .dirty_mask(dirty_mask),
    .hold(hold), .busy(busy), .done(done), .tile_index(tile_index), .tile_value(tile_value),
    .x_origin(x_origin), .y_origin(y_origin), .glyph_resetn(glyph_resetn),
    .glyph_enable(glyph_enable), .plot(plot)
  );
  // Runs one pass; len is the cycle (after the start edge) on which done is seen, -1 on timeout.
  // Inputs are scrambled right after start so any re-sampling would show up.
  task automatic run_pass(input logic [63:0] b, input logic [15:0] m, input int hs, input int hl,
                          output int len, output int plots, output int clears, output int max_run,
                          output int bad, output logic [18:0] org);
    int run = 0, hc = 0;
    len = -1; plots = 0; clears = 0; max_run = 0; bad = 0; org = '0;
    @(negedge clk); board = b; dirty_mask = m; start = 1;
    for (int k = 1; k < 5000; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 0; board = ~b; dirty_mask = ~m; end
      hold = (hl > 0) && (plots >= hs) && (hc < hl);
      if (hold) hc++;
      #1;
      if (hold && plot) bad++;
      if (!busy) bad++;
      if (!glyph_resetn && glyph_enable) bad++;
      if (plot) begin
        plots++; run++;
        if (plots == 1) org = {x_origin, y_origin, tile_value};
        if (run > max_run) max_run = run;
      end else run = 0;
      if (!glyph_resetn) clears++;
      if (done) begin len = k; break; end
    end
    hold = 0;
  endtask
  task automatic test_reset();
    resetn = 0;
    repeat (3) @(negedge clk);
    resetn = 1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (plot !== 1'b0) $display("FAIL reset_plot: got %b want 0", plot); else passed++;
    total++; if (glyph_resetn !== 1'b1) $display("FAIL reset_glyph_resetn: got %b want 1", glyph_resetn); else passed++;
    total++; if (tile_index !== 4'd0) $display("FAIL reset_tile_index: got %0d want 0", tile_index); else passed++;
    total++; if (glyph_enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", glyph_enable); else passed++;
  endtask
  task automatic test_empty();
    int len, plots, clears, mr, bad; logic [18:0] org;
    run_pass(64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 0, 0, len, plots, clears, mr, bad, org);
    total++; if (len !== 17) $display("FAIL empty_len: got %0d want 17", len); else passed++;
    total++; if (plots !== 0) $display("FAIL empty_plots: got %0d want 0", plots); else passed++;
    total++; if (clears !== 0) $display("FAIL empty_clears: got %0d want 0", clears); else passed++;
    total++; if (bad !== 0) $display("FAIL empty_protocol: got %0d want 0", bad); else passed++;
    @(negedge clk); #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL empty_after: got busy,done=%b want 00", {busy, done}); else passed++;
  endtask
  task automatic test_single();
    int len, plots, clears, mr, bad; logic [18:0] org;
    run_pass(64'h1111_1111_1111_111E, 16'h0001, 0, 0, len, plots, clears, mr, bad, org);
    total++; if (len !== 139) $display("FAIL single_len: got %0d want 139", len); else passed++;
    total++; if (plots !== 121) $display("FAIL single_plots: got %0d want 121", plots); else passed++;
    total++; if (mr !== 121) $display("FAIL single_run: got %0d want 121", mr); else passed++;
    total++; if (clears !== 1) $display("FAIL single_clears: got %0d want 1", clears); else passed++;
    total++; if (org !== {8'd0, 7'd0, 4'd14}) $display("FAIL single_origin: got %h want %h", org, {8'd0, 7'd0, 4'd14}); else passed++;
    total++; if (bad !== 0) $display("FAIL single_protocol: got %0d want 0", bad); else passed++;
    @(negedge clk); #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL single_after: got busy,done=%b want 00", {busy, done}); else passed++;
  endtask
  task automatic test_origin_skip();
    int len, plots, clears, mr, bad; logic [18:0] org;
    run_pass(64'h0000_0000_0070_0000, 16'h0030, 0, 0, len, plots, clears, mr, bad, org);
    total++; if (len !== 139) $display("FAIL skip_len: got %0d want 139", len); else passed++;
    total++; if (plots !== 121) $display("FAIL skip_plots: got %0d want 121", plots); else passed++;
    total++; if (clears !== 1) $display("FAIL skip_clears: got %0d want 1", clears); else passed++;
    total++; if (org !== {8'd30, 7'd30, 4'd7}) $display("FAIL skip_origin: got %h want %h", org, {8'd30, 7'd30, 4'd7}); else passed++;
  endtask
  task automatic test_hold();
    int len, plots, clears, mr, bad; logic [18:0] org;
    run_pass(64'h0000_0500_0000_0000, 16'h0400, 50, 10, len, plots, clears, mr, bad, org);
    total++; if (len !== 149) $display("FAIL hold_len: got %0d want 149", len); else passed++;
    total++; if (plots !== 121) $display("FAIL hold_plots: got %0d want 121", plots); else passed++;
    total++; if (mr !== 71) $display("FAIL hold_run: got %0d want 71", mr); else passed++;
    total++; if (bad !== 0) $display("FAIL hold_protocol: got %0d want 0", bad); else passed++;
    total++; if (org !== {8'd60, 7'd60, 4'd5}) $display("FAIL hold_origin: got %h want %h", org, {8'd60, 7'd60, 4'd5}); else passed++;
  endtask
  task automatic test_back_to_back();
    int len, plots, clears, mr, bad; logic [18:0] org;
    run_pass(64'h1111_1111_1111_0111, 16'hFFFF, 0, 0, len, plots, clears, mr, bad, org);
    total++; if (len !== 1847) $display("FAIL b2b_len: got %0d want 1847", len); else passed++;
    total++; if (plots !== 1815) $display("FAIL b2b_plots: got %0d want 1815", plots); else passed++;
    total++; if (clears !== 15) $display("FAIL b2b_clears: got %0d want 15", clears); else passed++;
    total++; if (mr !== 121) $display("FAIL b2b_run: got %0d want 121", mr); else passed++;
  endtask
  task automatic test_abort();
    int p = 0, saw_done = 0;
    int len, plots, clears, mr, bad; logic [18:0] org;
    @(negedge clk); board = 64'h3; dirty_mask = 16'h0001; start = 1;
    for (int k = 0; k < 400 && p < 30; k++) begin
      @(negedge clk); start = 0; #1;
      if (plot) p++;
      if (done) saw_done++;
    end
    @(negedge clk); start = 1; board = '1; dirty_mask = '1; #1;
    if (plot) p++;
    @(negedge clk); start = 0; #1;
    if (plot) p++;
    total++; if ({tile_index, tile_value, plot} !== {4'd0, 4'd3, 1'b1}) $display("FAIL abort_ignore_start: got idx=%0d val=%0d plot=%b want 0 3 1", tile_index, tile_value, plot); else passed++;
    for (int k = 0; k < 400 && p < 60; k++) begin
      @(negedge clk); #1;
      if (plot) p++;
      if (done) saw_done++;
    end
    total++; if (p !== 60) $display("FAIL abort_reach60: got %0d want 60", p); else passed++;
    @(negedge clk); resetn = 0; #1;
    total++; if ({busy, done, plot, glyph_resetn} !== 4'b0001) $display("FAIL abort_outputs: got %b want 0001", {busy, done, plot, glyph_resetn}); else passed++;
    total++; if (tile_index !== 4'd0) $display("FAIL abort_index: got %0d want 0", tile_index); else passed++;
    total++; if (saw_done !== 0) $display("FAIL abort_done: got %0d want 0", saw_done); else passed++;
    @(negedge clk); resetn = 1;
    run_pass(64'h9000_0000_0000_0000, 16'h8000, 0, 0, len, plots, clears, mr, bad, org);
    total++; if (len !== 139) $display("FAIL restart_len: got %0d want 139", len); else passed++;
    total++; if (plots !== 121) $display("FAIL restart_plots: got %0d want 121", plots); else passed++;
    total++; if (org !== {8'd90, 7'd90, 4'd9}) $display("FAIL restart_origin: got %h want %h", org, {8'd90, 7'd90, 4'd9}); else passed++;
  endtask
  initial begin
    test_reset();
    test_empty();
    test_single();
    test_origin_skip();
    test_hold();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
